// File: rtl/edit_fifo_pkg.sv
// Shared constants, pointer-width helper and per-cycle operation decode for edit_fifo.
package edit_fifo_pkg;

  localparam int unsigned DefDataW = 2;
  localparam int unsigned DefDepth = 256;

  // Write-side view of the cycle; read acceptance is resolved separately from re.
  typedef enum logic [2:0] {
    OpNop,
    OpWr,
    OpRd,
    OpRdWr,
    OpDel,
    OpRepl,
    OpFlush
  } op_e;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic op_e decode_op(input logic flush, input logic we, input logic re,
                                    input logic del);
    if (flush)           return OpFlush;
    else if (we && del)  return OpRepl;
    else if (del)        return OpDel;
    else if (we && re)   return OpRdWr;
    else if (we)         return OpWr;
    else if (re)         return OpRd;
    else                 return OpNop;
  endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read, no reset.
module fifo_sdp_ram #(
  parameter int unsigned DATA_W = 2,
  parameter int unsigned DEPTH  = 256,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write: a same-address read returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/edit_fifo.sv
// Parametrised symbol FIFO with occupancy, programmable thresholds, flush,
// delete/replace-newest and sticky overflow/underflow flags.
module edit_fifo
  import edit_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned AF_LEVEL = DEPTH - 4,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      re,
  input  logic                      del,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         data_in,
  output logic [DATA_W-1:0]         data_out,
  output logic                      out_valid,
  output logic [ptr_w(DEPTH)-1:0]   count,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] One    = PW'(1);
  localparam logic [PW-1:0] DepthC = PW'(DEPTH);
  localparam logic [PW-1:0] AfLvl  = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AeLvl  = PW'(AE_LEVEL);

  logic [PW-1:0] r_ptr_q, r_ptr_d, w_ptr_q, w_ptr_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          out_valid_q, rd_seen_q;
  logic          rd_ok, plain_wr, wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] n_left, w_last;
  logic [DATA_W-1:0] ram_rd;
  op_e           op;

  assign count        = w_ptr_q - r_ptr_q;
  assign empty        = (count == '0);
  assign full         = (count == DepthC);
  assign almost_full  = (count >= AfLvl);
  assign almost_empty = (count <= AeLvl);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign out_valid    = out_valid_q;
  // RAM output is unreset, so mask it until the first accepted read.
  assign data_out     = rd_seen_q ? ram_rd : '0;

  assign op     = decode_op(flush, we, re, del);
  assign rd_ok  = re && !empty && (op != OpFlush);
  assign n_left = count - (rd_ok ? One : '0);
  assign w_last = w_ptr_q - One;

  always_comb begin
    r_ptr_d  = r_ptr_q;
    w_ptr_d  = w_ptr_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    plain_wr = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = w_ptr_q[AW-1:0];
    if (op == OpFlush) begin
      r_ptr_d = w_ptr_q;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      if (rd_ok)   r_ptr_d = r_ptr_q + One;
      else if (re) udf_d   = 1'b1;
      case (op)
        OpWr, OpRdWr: plain_wr = 1'b1;
        OpRepl: begin
          if (n_left != '0) begin
            wr_en   = 1'b1;
            wr_addr = w_last[AW-1:0];
          end else begin
            plain_wr = 1'b1;
          end
        end
        OpDel: begin
          if (n_left != '0) w_ptr_d = w_last;
        end
        default: ;
      endcase
      if (plain_wr) begin
        if (!full || rd_ok) begin
          wr_en   = 1'b1;
          w_ptr_d = w_ptr_q + One;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr_q     <= '0;
      w_ptr_q     <= '0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      r_ptr_q     <= r_ptr_d;
      w_ptr_q     <= w_ptr_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      out_valid_q <= rd_ok;
      rd_seen_q   <= rd_seen_q | rd_ok;
    end
  end

  fifo_sdp_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (data_in),
    .rd_en   (rd_ok),
    .rd_addr (r_ptr_q[AW-1:0]),
    .rd_data (ram_rd)
  );

endmodule
